ov5640_cfg_seq: RTL

Configuration sequencer for the OV5640 register look-up table. It walks the table index from 0 and fetches each 32-bit entry (8-bit device address, 16-bit register address, 8-bit data). For each entry it issues one write transaction to the downstream I2C master over a req/done handshake, and it stops at the terminator entry. It sits between the camera register LUT and the I2C master, and gives the rest of the design busy, done and error status for sensor bring-up.

---
 rtl/ov5640_cfg_seq.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/ov5640_cfg_seq.sv
// ov5640_cfg_seq: walks the OV5640 register LUT and issues one I2C write per entry.
// Define OV5640_CFG_NACK_RETRY_EN to retry NACKed writes up to MAX_RETRY times.
module ov5640_cfg_seq #(
  parameter int unsigned INIT_DELAY = 1_000_000,
  parameter int unsigned MAX_RETRY  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [9:0]  lut_index,
  input  logic [31:0] lut_data,
  output logic        i2c_write_req,
  output logic [7:0]  i2c_slave_addr,
  output logic [15:0] i2c_reg_addr,
  output logic [7:0]  i2c_write_data,
  input  logic        i2c_done,
  input  logic        i2c_ack_err,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_error
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_PWR,
    FETCH,
    ISSUE,
    WAIT_DONE,
    NEXT,
    DONE,
    ERROR
  } state_t;

  // FETCH lands INIT_DELAY cycles after start, so WAIT_PWR lasts INIT_DELAY-1.
  localparam logic [31:0] DLY_LAST =
    (INIT_DELAY > 2) ? 32'(INIT_DELAY - 2) : 32'd0;

  state_t      state, state_d;
  logic [31:0] dly_cnt, dly_d;
  logic [9:0]  idx_d;
  logic        req_d;
  logic [7:0]  dev_d;
  logic [15:0] reg_d;
  logic [7:0]  dat_d;
  logic        busy_d;
  logic        done_d;
  logic        err_d;
`ifdef OV5640_CFG_NACK_RETRY_EN
  logic [31:0] retry_cnt, retry_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      dly_cnt        <= '0;
      lut_index      <= '0;
      i2c_write_req  <= 1'b0;
      i2c_slave_addr <= '0;
      i2c_reg_addr   <= '0;
      i2c_write_data <= '0;
      cfg_busy       <= 1'b0;
      cfg_done       <= 1'b0;
      cfg_error      <= 1'b0;
`ifdef OV5640_CFG_NACK_RETRY_EN
      retry_cnt      <= '0;
`endif
    end else begin
      state          <= state_d;
      dly_cnt        <= dly_d;
      lut_index      <= idx_d;
      i2c_write_req  <= req_d;
      i2c_slave_addr <= dev_d;
      i2c_reg_addr   <= reg_d;
      i2c_write_data <= dat_d;
      cfg_busy       <= busy_d;
      cfg_done       <= done_d;
      cfg_error      <= err_d;
`ifdef OV5640_CFG_NACK_RETRY_EN
      retry_cnt      <= retry_d;
`endif
    end
  end

  always_comb begin
    state_d = state;
    dly_d   = dly_cnt;
    idx_d   = lut_index;
    req_d   = i2c_write_req;
    dev_d   = i2c_slave_addr;
    reg_d   = i2c_reg_addr;
    dat_d   = i2c_write_data;
    busy_d  = cfg_busy;
    done_d  = cfg_done;
    err_d   = cfg_error;
`ifdef OV5640_CFG_NACK_RETRY_EN
    retry_d = retry_cnt;
`endif
    unique case (state)
      IDLE, DONE, ERROR: begin
        if (start) begin
          idx_d   = '0;
          dly_d   = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = WAIT_PWR;
        end
      end
      WAIT_PWR: begin
        if (dly_cnt >= DLY_LAST) state_d = FETCH;
        else dly_d = dly_cnt + 32'd1;
      end
      FETCH: begin
        if (lut_data[31:24] == 8'hFF) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end else if (lut_data[31:24] == 8'h00) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = ERROR;
        end else begin
          dev_d   = lut_data[31:24];
          reg_d   = lut_data[23:8];
          dat_d   = lut_data[7:0];
`ifdef OV5640_CFG_NACK_RETRY_EN
          retry_d = '0;
`endif
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        req_d   = 1'b1;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (i2c_done) begin
          req_d = 1'b0;
          if (!i2c_ack_err) begin
            state_d = NEXT;
          end else begin
`ifdef OV5640_CFG_NACK_RETRY_EN
            if (retry_cnt < MAX_RETRY) begin
              retry_d = retry_cnt + 32'd1;
              state_d = ISSUE;
            end else begin
              err_d   = 1'b1;
              busy_d  = 1'b0;
              state_d = ERROR;
            end
`else
            err_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = ERROR;
`endif
          end
        end
      end
      NEXT: begin
        if (lut_index == 10'd1023) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = ERROR;
        end else begin
          idx_d   = lut_index + 10'd1;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
